// File: rtl/timer_dev_pkg.sv
// ----------------------------------------------------------------------------
// timer_dev_pkg
//   Shared constants and helpers for the memory-mapped countdown timer:
//   - bus word addresses (Addr = bus byte address [3:2])
//   - CTRL field positions and mode encodings
//   - bus write-enable level
//   - 2-bit FSM state encodings
//   - packed CTRL register type with pack/unpack helpers
// ----------------------------------------------------------------------------
package timer_dev_pkg;

  // Register word select
  localparam logic [1:0] TMR_ADDR_CTRL   = 2'b00;
  localparam logic [1:0] TMR_ADDR_PRESET = 2'b01;
  localparam logic [1:0] TMR_ADDR_COUNT  = 2'b10;
  localparam logic [1:0] TMR_ADDR_RSVD   = 2'b11;

  // CTRL[2:1] mode encodings; 1x behaves as one-shot
  localparam logic [1:0] TMR_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] TMR_MODE_RELOAD  = 2'b01;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // Bus write strobe level
  localparam logic WR_EN = 1'b1;

  // FSM state encodings
  localparam logic [1:0] TMR_IDLE = 2'b00;
  localparam logic [1:0] TMR_LOAD = 2'b01;
  localparam logic [1:0] TMR_CNT  = 2'b10;
  localparam logic [1:0] TMR_INT  = 2'b11;

  // CTRL register contents (only the four implemented bits are stored)
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       enable;
  } ctrl_t;

  // Unpack the implemented CTRL bits from a bus write
  function automatic ctrl_t ctrl_from_bits(input logic [3:0] b);
    ctrl_t c;
    c.enable = b[CTRL_EN_BIT];
    c.mode   = b[CTRL_MODE_MSB:CTRL_MODE_LSB];
    c.im     = b[CTRL_IM_BIT];
    return c;
  endfunction

  // Pack CTRL into a 32-bit read word; unimplemented bits read as 0
  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN_BIT]                 = c.enable;
    w[CTRL_MODE_MSB:CTRL_MODE_LSB] = c.mode;
    w[CTRL_IM_BIT]                 = c.im;
    return w;
  endfunction

  // Collapse the mode field to the two behaviours the timer implements
  function automatic logic [1:0] mode_effective(input logic [1:0] m);
    return (m == TMR_MODE_RELOAD) ? TMR_MODE_RELOAD : TMR_MODE_ONESHOT;
  endfunction

endpackage

// File: rtl/timer_dev.sv
// ----------------------------------------------------------------------------
// timer_dev
//   Memory-mapped countdown timer acting as a CP0 HWInt interrupt source.
//   One-shot or auto-reload operation, maskable IRQ that is sticky in one-shot
//   mode and a single-cycle pulse in auto-reload mode.
//
// Parameters
//   WIDTH  Width of PRESET and COUNT (2..32). Upper read bits return 0.
//
// Ports
//   clk    in   1   system clock, all state changes on the rising edge
//   reset  in   1   asynchronous reset, active low
//   Addr   in   2   word select: 00 CTRL, 01 PRESET, 10 COUNT, 11 reserved
//   Wen    in   1   write enable, sampled on the rising edge
//   Din    in   32  write data
//   DOut   out  32  combinational read of the register selected by Addr
//   IRQ    out  1   interrupt request = irq_pending & CTRL.IM
// ----------------------------------------------------------------------------
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        Wen,
  input  logic [31:0] Din,
  output logic [31:0] DOut,
  output logic        IRQ
);

  localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

  ctrl_t            ctrl_reg, ctrl_next;
  logic [WIDTH-1:0] preset_reg, preset_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [1:0]       state_reg, state_next;
  logic             irq_pending_reg, irq_pending_next;
  logic             irq_set;

  logic wr_ctrl;
  logic wr_preset;

  // COUNT and the reserved word are not writable, so only two strobes exist
  assign wr_ctrl   = (Wen == WR_EN) && (Addr == TMR_ADDR_CTRL);
  assign wr_preset = (Wen == WR_EN) && (Addr == TMR_ADDR_PRESET);

  // --------------------------------------------------------------------------
  // Next-state logic. The FSM acts on the registered CTRL/PRESET values, so a
  // bus write is seen by the FSM one edge later. Bus writes are applied last
  // so that a CTRL write overrides the one-shot Enable clear in INT.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    ctrl_next        = ctrl_reg;
    preset_next      = preset_reg;
    count_next       = count_reg;
    irq_pending_next = irq_pending_reg;
    irq_set          = 1'b0;

    case (state_reg)
      TMR_IDLE: begin
        if (ctrl_reg.enable) begin
          state_next = TMR_LOAD;
        end
      end

      TMR_LOAD: begin
        // Disabling before the load happens abandons it entirely
        if (!ctrl_reg.enable) begin
          state_next = TMR_IDLE;
        end else begin
          count_next = preset_reg;
          state_next = TMR_CNT;
        end
      end

      TMR_CNT: begin
        if (!ctrl_reg.enable) begin
          state_next = TMR_IDLE;
        end else if (count_reg > COUNT_ONE) begin
          count_next = count_reg - COUNT_ONE;
        end else begin
          // Reaching 1 (or a loaded 0) expires; COUNT saturates at 0
          count_next = '0;
          irq_set    = 1'b1;
          state_next = TMR_INT;
        end
      end

      TMR_INT: begin
        if (mode_effective(ctrl_reg.mode) == TMR_MODE_RELOAD) begin
          // Pending lasts only the INT cycle, giving a one-cycle IRQ pulse
          irq_pending_next = 1'b0;
          state_next       = TMR_LOAD;
        end else begin
          ctrl_next.enable = 1'b0;
          state_next       = TMR_IDLE;
        end
      end

      default: begin
        state_next = TMR_IDLE;
      end
    endcase

    // An expiry on the same edge as a clearing write keeps the request
    if (irq_set) begin
      irq_pending_next = 1'b1;
    end else if (wr_ctrl || wr_preset) begin
      irq_pending_next = 1'b0;
    end

    if (wr_ctrl) begin
      ctrl_next = ctrl_from_bits(Din[3:0]);
    end

    // A new PRESET never disturbs a running count; it is used at the next LOAD
    if (wr_preset) begin
      preset_next = Din[WIDTH-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_reg        <= '0;
      preset_reg      <= '0;
      count_reg       <= '0;
      state_reg       <= TMR_IDLE;
      irq_pending_reg <= 1'b0;
    end else begin
      ctrl_reg        <= ctrl_next;
      preset_reg      <= preset_next;
      count_reg       <= count_next;
      state_reg       <= state_next;
      irq_pending_reg <= irq_pending_next;
    end
  end

  // --------------------------------------------------------------------------
  // Bus read and interrupt output
  // --------------------------------------------------------------------------
  always_comb begin
    DOut = '0;
    case (Addr)
      TMR_ADDR_CTRL:   DOut = ctrl_to_word(ctrl_reg);
      TMR_ADDR_PRESET: DOut[WIDTH-1:0] = preset_reg;
      TMR_ADDR_COUNT:  DOut[WIDTH-1:0] = count_reg;
      TMR_ADDR_RSVD:   DOut = '0;
      default:         DOut = '0;
    endcase
  end

  assign IRQ = irq_pending_reg & ctrl_reg.im;

endmodule
